// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared constants for the motor drive controller: command codes, H-bridge
// direction encodings, per-motor FSM states and the command decoder.
package motor_pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } mstate_e;

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    localparam logic [1:0] MODE_DRIVE = 2'b10;

    localparam logic [5:0] CMD_FWD   = 6'h01;
    localparam logic [5:0] CMD_REV   = 6'h02;
    localparam logic [5:0] CMD_LEFT  = 6'h03;
    localparam logic [5:0] CMD_RIGHT = 6'h04;
    localparam logic [5:0] CMD_STOP  = 6'h09;

    // Returns {right_dir, left_dir}; anything unrecognised decodes as stop.
    function automatic logic [3:0] decode_cmd(input logic [5:0] c);
        logic [3:0] d;
        case (c)
            CMD_FWD:   d = {DIR_FWD, DIR_FWD};
            CMD_REV:   d = {DIR_REV, DIR_REV};
            CMD_LEFT:  d = {DIR_FWD, DIR_REV};
            CMD_RIGHT: d = {DIR_REV, DIR_FWD};
            default:   d = {DIR_OFF, DIR_OFF};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/motor_pwm_ctrl_motor_chan.sv
// One motor channel: STOP/RUN/DEAD FSM, duty ramp toward target, dead-time
// counter on reversal, and a registered PWM enable.
module motor_chan
    import motor_pwm_ctrl_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 16,
    parameter int RAMP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       tgt_dir,
    input  logic [PWM_W-1:0] tgt_spd,
    input  logic [PWM_W-1:0] cnt_nxt,
    output logic [1:0]       dir,
    output logic             pwm,
    output logic             dead,
    output logic             busy
);

    localparam int DEAD_W = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);
    localparam int RAMP_W = (RAMP_DIV < 2) ? 1 : $clog2(RAMP_DIV + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = 1;
    localparam logic [RAMP_W-1:0] RAMP_ONE  = 1;
    localparam logic [PWM_W-1:0]  DUTY_ONE  = 1;

    mstate_e           state, state_n;
    logic [1:0]        dir_n;
    logic [PWM_W-1:0]  duty, duty_n;
    logic [DEAD_W-1:0] dcnt, dcnt_n;
    logic [RAMP_W-1:0] rcnt, rcnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
            dir   <= DIR_OFF;
            duty  <= '0;
            dcnt  <= '0;
            rcnt  <= '0;
            pwm   <= 1'b0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            duty  <= duty_n;
            dcnt  <= dcnt_n;
            rcnt  <= rcnt_n;
            // Built from next-state values so pwm never lags dir/duty.
            pwm   <= (cnt_nxt < duty_n) && (dir_n != DIR_OFF);
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        duty_n  = duty;
        dcnt_n  = dcnt;
        rcnt_n  = rcnt;
        if (!enable) begin
            state_n = ST_STOP;
            dir_n   = DIR_OFF;
            duty_n  = '0;
            dcnt_n  = '0;
            rcnt_n  = '0;
        end else begin
            case (state)
                ST_STOP: begin
                    if (tgt_dir != DIR_OFF) begin
                        state_n = ST_RUN;
                        dir_n   = tgt_dir;
                        duty_n  = '0;
                        rcnt_n  = '0;
                    end
                end
                ST_RUN: begin
                    if (tgt_dir == DIR_OFF) begin
                        state_n = ST_STOP;
                        dir_n   = DIR_OFF;
                        duty_n  = '0;
                        rcnt_n  = '0;
                    end else if (tgt_dir != dir) begin
                        state_n = ST_DEAD;
                        dir_n   = DIR_OFF;
                        duty_n  = '0;
                        dcnt_n  = DEAD_LOAD;
                        rcnt_n  = '0;
                    end else if (duty != tgt_spd) begin
                        if (rcnt == RAMP_LAST) begin
                            rcnt_n = '0;
                            duty_n = (duty < tgt_spd) ? duty + DUTY_ONE : duty - DUTY_ONE;
                        end else begin
                            rcnt_n = rcnt + RAMP_ONE;
                        end
                    end else begin
                        rcnt_n = '0;
                    end
                end
                ST_DEAD: begin
                    // The pending direction is whatever the target says at expiry,
                    // so a stop during dead time lands in STOP.
                    if (dcnt == '0) begin
                        if (tgt_dir == DIR_OFF) begin
                            state_n = ST_STOP;
                        end else begin
                            state_n = ST_RUN;
                            dir_n   = tgt_dir;
                        end
                        duty_n = '0;
                        rcnt_n = '0;
                    end else begin
                        dcnt_n = dcnt - DEAD_ONE;
                    end
                end
                default: begin
                    state_n = ST_STOP;
                    dir_n   = DIR_OFF;
                    duty_n  = '0;
                end
            endcase
        end
    end

    assign dead = (state == ST_DEAD);
    assign busy = dead || ((state == ST_RUN) && (duty != tgt_spd));

endmodule

// File: rtl/motor_pwm_ctrl.sv
// N-motor H-bridge drive controller: command decode, shared PWM counter,
// mode gating and handshake; per-motor behaviour lives in motor_chan.
module motor_pwm_ctrl
    import motor_pwm_ctrl_pkg::*;
#(
    parameter int N_MOTORS = 2,
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 16,
    parameter int RAMP_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            model_s,
    input  logic                  cmd_valid,
    input  logic [5:0]            cmd,
    input  logic [PWM_W-1:0]      cmd_speed,
    output logic                  cmd_ready,
    output logic [2*N_MOTORS-1:0] motor_dir,
    output logic [N_MOTORS-1:0]   motor_pwm,
    output logic [1:0]            model_o,
    output logic                  busy
);

    localparam logic [PWM_W-1:0] CNT_ONE = 1;

    logic                         mode_ok;
    logic                         accept;
    logic [3:0]                   dec;
    logic [PWM_W-1:0]             cnt, cnt_nxt;
    logic [N_MOTORS-1:0][1:0]     tgt_dir;
    logic [PWM_W-1:0]             tgt_spd;
    logic [N_MOTORS-1:0][1:0]     dir_w;
    logic [N_MOTORS-1:0]          dead_w, busy_w;

    assign mode_ok   = (model_s == MODE_DRIVE);
    assign cmd_ready = mode_ok && !(|dead_w);
    assign accept    = cmd_valid && cmd_ready;
    assign dec       = decode_cmd(cmd);
    assign cnt_nxt   = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_o <= 2'b00;
            cnt     <= '0;
            tgt_dir <= '0;
            tgt_spd <= '0;
        end else begin
            model_o <= model_s;
            cnt     <= cnt_nxt;
            if (!mode_ok) begin
                tgt_dir <= '0;
                tgt_spd <= '0;
            end else if (accept) begin
                for (int k = 0; k < N_MOTORS; k++)
                    tgt_dir[k] <= (k % 2 == 1) ? dec[3:2] : dec[1:0];
                tgt_spd <= (dec == 4'b0000) ? '0 : cmd_speed;
            end
        end
    end

    for (genvar k = 0; k < N_MOTORS; k++) begin : g_chan
        motor_chan #(
            .PWM_W   (PWM_W),
            .DEAD_CYC(DEAD_CYC),
            .RAMP_DIV(RAMP_DIV)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (mode_ok),
            .tgt_dir(tgt_dir[k]),
            .tgt_spd(tgt_spd),
            .cnt_nxt(cnt_nxt),
            .dir    (dir_w[k]),
            .pwm    (motor_pwm[k]),
            .dead   (dead_w[k]),
            .busy   (busy_w[k])
        );
    end

    assign motor_dir = dir_w;
    assign busy      = |busy_w;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed bench for motor_pwm_ctrl: drive, reversal dead time, turning, stop,
// mode exit, undefined codes, duty extremes and mid-run reset.
module tb_motor_pwm_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] model_s;
    logic       cmd_valid;
    logic [5:0] cmd;
    logic [7:0] cmd_speed;
    logic       cmd_ready;
    logic [3:0] motor_dir;
    logic [1:0] motor_pwm;
    logic [1:0] model_o;
    logic       busy;

    int checks = 0;
    int errors = 0;

    motor_pwm_ctrl #(.N_MOTORS(2), .PWM_W(8), .DEAD_CYC(16), .RAMP_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .model_s  (model_s),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_speed(cmd_speed),
        .cmd_ready(cmd_ready),
        .motor_dir(motor_dir),
        .motor_pwm(motor_pwm),
        .model_o  (model_o),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one command (cmd_ready is expected high) and drop the strobe.
    task automatic send(input logic [5:0] c, input logic [7:0] s);
        cmd = c;
        cmd_speed = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_pwm(input int idx, output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (motor_pwm[idx]) hi++;
        end
    endtask

    initial begin
        int hi;
        int zeros;
        rst_n = 1'b0;
        model_s = 2'b00;
        cmd_valid = 1'b0;
        cmd = 6'h00;
        cmd_speed = 8'h00;
        tick(3);
        chk("reset_dir", motor_dir, 4'b0000);
        chk("reset_pwm", motor_pwm, 2'b00);
        chk("reset_model_o", model_o, 2'b00);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        model_s = 2'b10;
        tick();
        chk("model_o_drive", model_o, 2'b10);
        chk("ready_idle", cmd_ready, 1'b1);

        // 1. forward at 0x80
        send(6'h01, 8'h80);
        chk("fwd_latency1", motor_dir, 4'b0000);
        tick();
        chk("fwd_dir", motor_dir, 4'b1010);
        chk("fwd_busy", busy, 1'b1);
        tick(511);
        chk("ramp_not_done", busy, 1'b1);
        tick();
        chk("ramp_done", busy, 1'b0);
        count_pwm(0, hi);
        chk("pwm_128", hi, 128);
        count_pwm(1, hi);
        chk("pwm_128_r", hi, 128);

        // 2. reversal with dead time
        send(6'h02, 8'h80);
        chk("rev_latency1", motor_dir, 4'b1010);
        tick();
        chk("dead_dir", motor_dir, 4'b0000);
        chk("dead_ready", cmd_ready, 1'b0);
        chk("dead_busy", busy, 1'b1);
        zeros = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (motor_dir != 4'b0000) break;
            zeros++;
        end
        chk("dead_len", zeros, 16);
        chk("rev_dir", motor_dir, 4'b0101);
        chk("rev_pwm_from0", motor_pwm, 2'b00);
        chk("rev_ready", cmd_ready, 1'b1);
        tick(40);

        // 3. turn left: only the right motor reverses
        send(6'h03, 8'h40);
        tick();
        chk("left_dead_r", motor_dir, 4'b0001);
        chk("left_ready", cmd_ready, 1'b0);
        tick(15);
        chk("left_dead_end", motor_dir, 4'b0001);
        tick();
        chk("left_dir", motor_dir, 4'b1001);
        send(6'h09, 8'h55);
        chk("stop_latency1", motor_dir, 4'b1001);
        tick();
        chk("stop_dir", motor_dir, 4'b0000);
        chk("stop_pwm", motor_pwm, 2'b00);
        chk("stop_busy", busy, 1'b0);

        // 4. leave drive mode mid-ramp
        send(6'h01, 8'hFF);
        tick();
        chk("m4_dir", motor_dir, 4'b1010);
        tick(20);
        model_s = 2'b01;
        cmd_valid = 1'b1;
        cmd = 6'h02;
        #1;
        chk("mode_ready", cmd_ready, 1'b0);
        tick();
        chk("mode_dir", motor_dir, 4'b0000);
        chk("mode_pwm", motor_pwm, 2'b00);
        chk("mode_model_o", model_o, 2'b01);
        chk("mode_busy", busy, 1'b0);
        tick();
        chk("mode_ignored", motor_dir, 4'b0000);
        model_s = 2'b10;
        cmd_valid = 1'b0;
        tick(3);
        chk("mode_back_idle", motor_dir, 4'b0000);

        // 5. undefined code, full duty, zero duty
        send(6'h01, 8'hFF);
        tick();
        chk("m5_dir", motor_dir, 4'b1010);
        send(6'h3F, 8'h12);
        tick();
        chk("undef_dir", motor_dir, 4'b0000);
        chk("undef_busy", busy, 1'b0);
        send(6'h01, 8'hFF);
        tick(1024);
        chk("ff_ramp_done", busy, 1'b0);
        count_pwm(1, hi);
        chk("pwm_255", hi, 255);
        send(6'h09, 8'h00);
        tick();
        send(6'h01, 8'h00);
        tick();
        chk("zero_dir", motor_dir, 4'b1010);
        chk("zero_busy", busy, 1'b0);
        count_pwm(0, hi);
        chk("pwm_0", hi, 0);

        // 6. reset during dead time
        send(6'h02, 8'h40);
        tick(6);
        chk("pre_rst_dead", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_dir", motor_dir, 4'b0000);
        chk("rst_pwm", motor_pwm, 2'b00);
        chk("rst_model_o", model_o, 2'b00);
        chk("rst_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        send(6'h01, 8'h80);
        tick();
        chk("post_rst_dir", motor_dir, 4'b1010);
        chk("post_rst_pwm", motor_pwm, 2'b00);
        chk("post_rst_busy", busy, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
